// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Rotation puts the search start at bit 3 of the rotated vector.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Rotate right by sh: result bit j is vec[(j+sh) mod 4].
    function automatic logic [N_REQ-1:0] rot4(
        input logic [N_REQ-1:0] vec,
        input logic [IDX_W-1:0] sh
    );
        logic [2*N_REQ-1:0] dbl;
        dbl = {vec, vec} >> sh;
        return dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between requesters (master) and arbiter (slave).
// rel is the owner's release strobe.
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             rel;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (
        output req, rel,
        input  gnt, gnt_idx, gnt_valid
    );

    modport slave (
        input  req, rel,
        output gnt, gnt_idx, gnt_valid
    );

endinterface

// File: rtl/prio_enc_4.sv
// Four-to-two priority encoder, highest set bit wins.
// All-zero input gives idx=0, valid=0.
module prio_enc_4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b1;
        unique casez (in)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            4'b0001: idx = 2'd0;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester arbiter with grant hold, timeout and round-robin rotation.
// Registered one-hot and encoded grant outputs.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter bit RR_EN    = 1'b1,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_4_if.slave bus
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    logic [N_REQ-1:0] cand, cand_rot, others;
    logic [IDX_W-1:0] enc_idx, win;
    logic             enc_valid, load, drop, tmo;

    assign others = bus.req & ~gnt_q;
    assign drop   = bus.rel | ~bus.req[idx_q];
    assign tmo    = (MAX_HOLD != 0) && (hold_q == HOLD_MAX)
                    && (|others);

    assign cand_rot = rot4(cand, ptr_q);

    prio_enc_4 u_enc (
        .in    (cand_rot),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // 2-bit add wraps naturally, undoing the rotation.
    assign win = enc_idx + ptr_q;

    always_comb begin
        cand    = bus.req;
        load    = 1'b0;
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: load = 1'b1;
            ST_GRANT: begin
                if (drop) begin
                    load = 1'b1;
                end else if (tmo) begin
                    cand = others;
                    load = 1'b1;
                end else if (MAX_HOLD != 0 && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: load = 1'b1;
        endcase
        if (load) begin
            if (enc_valid) begin
                state_d = ST_GRANT;
                gnt_d   = ONE << win;
                idx_d   = win;
                valid_d = 1'b1;
                hold_d  = HW'(1);
                if (RR_EN) ptr_d = win;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus random traffic
// compared against a search-order model, round-robin and fixed variants.
module tb_rr_arbiter_4;

    localparam int MAXH = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rel;

    int errs   = 0;
    int checks = 0;

    rr_arbiter_4_if bus_rr ();
    rr_arbiter_4_if bus_fx ();

    assign bus_rr.req = req;
    assign bus_rr.rel = rel;
    assign bus_fx.req = req;
    assign bus_fx.rel = rel;

    rr_arbiter_4 #(.RR_EN(1'b1), .MAX_HOLD(MAXH)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    rr_arbiter_4 #(.RR_EN(1'b0), .MAX_HOLD(MAXH)) u_fx (
        .clk (clk),
        .rst (rst),
        .bus (bus_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: owner (-1 idle), rotation pointer, hold count per variant.
    int m_own [2];
    int m_ptr [2];
    int m_hold[2];

    function automatic int pick(logic [3:0] c, int p);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (p - k + 8) % 4;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic [3:0] c;
            logic [3:0] oh;
            bit         ex;
            int         w;
            c  = req;
            ex = 1'b0;
            oh = (m_own[u] < 0) ? 4'b0000 : (4'b0001 << m_own[u]);
            if (rst) begin
                m_own[u]  = -1;
                m_ptr[u]  = 0;
                m_hold[u] = 0;
            end else begin
                if (m_own[u] < 0) begin
                    ex = 1'b1;
                end else if (rel || !req[m_own[u]]) begin
                    ex = 1'b1;
                end else if (m_hold[u] == MAXH && (req & ~oh) != 4'b0) begin
                    ex = 1'b1;
                    c  = req & ~oh;
                end else if (m_hold[u] < MAXH) begin
                    m_hold[u]++;
                end
                if (ex) begin
                    w = pick(c, m_ptr[u]);
                    m_own[u]  = w;
                    m_hold[u] = (w < 0) ? 0 : 1;
                    if (w >= 0 && u == 0) m_ptr[u] = w;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        rel = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        rel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus_rr.gnt !== 4'b0000 || bus_rr.gnt_idx !== 2'd0
                || bus_rr.gnt_valid !== 1'b0) begin
                errs++;
                $display("FAIL reset_out cyc%0d got gnt=%b idx=%0d v=%b want 0000/0/0",
                         i, bus_rr.gnt, bus_rr.gnt_idx, bus_rr.gnt_valid);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus_rr.gnt !== 4'b1000 || bus_rr.gnt_idx !== 2'd3) begin
            errs++;
            $display("FAIL reset_first got gnt=%b idx=%0d want 1000/3",
                     bus_rr.gnt, bus_rr.gnt_idx);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0101;
        tick();
        checks++;
        if (bus_rr.gnt !== 4'b0100 || bus_rr.gnt_idx !== 2'd2) begin
            errs++;
            $display("FAIL basic_grant got gnt=%b idx=%0d want 0100/2",
                     bus_rr.gnt, bus_rr.gnt_idx);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (bus_rr.gnt_valid !== 1'b0 || bus_rr.gnt !== 4'b0000) begin
            errs++;
            $display("FAIL basic_idle got gnt=%b v=%b want 0000/0",
                     bus_rr.gnt, bus_rr.gnt_valid);
        end
    endtask

    task automatic test_rotation();
        int exp_rr[4] = '{2, 1, 0, 3};
        do_reset();
        req = 4'b1111;
        tick();
        checks++;
        if (bus_rr.gnt_idx !== 2'd3 || bus_fx.gnt_idx !== 2'd3) begin
            errs++;
            $display("FAIL rot_first got rr=%0d fx=%0d want 3/3",
                     bus_rr.gnt_idx, bus_fx.gnt_idx);
        end
        for (int k = 0; k < 4; k++) begin
            rel = 1'b1;
            tick();
            rel = 1'b0;
            checks++;
            if (bus_rr.gnt_idx !== 2'(exp_rr[k]) || bus_rr.gnt_valid !== 1'b1) begin
                errs++;
                $display("FAIL rot_rr step%0d got idx=%0d v=%b want %0d/1",
                         k, bus_rr.gnt_idx, bus_rr.gnt_valid, exp_rr[k]);
            end
            checks++;
            if (bus_fx.gnt_idx !== 2'd3 || bus_fx.gnt_valid !== 1'b1) begin
                errs++;
                $display("FAIL rot_fx step%0d got idx=%0d v=%b want 3/1",
                         k, bus_fx.gnt_idx, bus_fx.gnt_valid);
            end
            tick();
            checks++;
            if (bus_rr.gnt_idx !== 2'(exp_rr[k])) begin
                errs++;
                $display("FAIL rot_hold step%0d got idx=%0d want %0d",
                         k, bus_rr.gnt_idx, exp_rr[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        int bad;
        do_reset();
        req = 4'b1001;
        n   = 0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (bus_rr.gnt !== 4'b1000) break;
            n++;
            tick();
        end
        checks++;
        if (n != MAXH) begin
            errs++;
            $display("FAIL tmo_len got %0d cycles want %0d", n, MAXH);
        end
        checks++;
        if (bus_rr.gnt !== 4'b0001) begin
            errs++;
            $display("FAIL tmo_next got gnt=%b want 0001", bus_rr.gnt);
        end
        req = 4'b1000;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus_rr.gnt !== 4'b1000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL tmo_alone got %0d cycles off 1000 want 0", bad);
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0011;
        tick();
        checks++;
        if (bus_rr.gnt !== 4'b0010 || bus_rr.gnt_valid !== 1'b1) begin
            errs++;
            $display("FAIL drop_next got gnt=%b v=%b want 0010/1",
                     bus_rr.gnt, bus_rr.gnt_valid);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (bus_rr.gnt_valid !== 1'b0) begin
            errs++;
            $display("FAIL drop_idle got v=%b want 0", bus_rr.gnt_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (bus_rr.gnt !== 4'b0010) begin
            errs++;
            $display("FAIL midrst_pre got gnt=%b want 0010", bus_rr.gnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus_rr.gnt !== 4'b0000 || bus_rr.gnt_valid !== 1'b0) begin
            errs++;
            $display("FAIL midrst_out got gnt=%b v=%b want 0000/0",
                     bus_rr.gnt, bus_rr.gnt_valid);
        end
        rst = 1'b0;
        req = 4'b1111;
        tick();
        checks++;
        if (bus_rr.gnt_idx !== 2'd3) begin
            errs++;
            $display("FAIL midrst_ptr got idx=%0d want 3", bus_rr.gnt_idx);
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            rel = ($urandom_range(0, 7) == 0);
            tick();
            eg = (m_own[0] < 0) ? 4'b0000 : (4'b0001 << m_own[0]);
            checks++;
            if (bus_rr.gnt !== eg || bus_rr.gnt_valid !== (m_own[0] >= 0)
                || (m_own[0] >= 0 && bus_rr.gnt_idx !== 2'(m_own[0]))) begin
                errs++;
                $display("FAIL rand_rr cyc%0d got gnt=%b idx=%0d want gnt=%b",
                         i, bus_rr.gnt, bus_rr.gnt_idx, eg);
            end
            eg = (m_own[1] < 0) ? 4'b0000 : (4'b0001 << m_own[1]);
            checks++;
            if (bus_fx.gnt !== eg || bus_fx.gnt_valid !== (m_own[1] >= 0)
                || (m_own[1] >= 0 && bus_fx.gnt_idx !== 2'(m_own[1]))) begin
                errs++;
                $display("FAIL rand_fx cyc%0d got gnt=%b idx=%0d want gnt=%b",
                         i, bus_fx.gnt, bus_fx.gnt_idx, eg);
            end
        end
        rel = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        rel = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_rotation();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
